// File: rtl/debug_slave_vjtag_host.sv
// ---------------------------------------------------------------------------
// debug_slave_vjtag_host
//
// Host-side driver for the Nios II debug-slave virtual-JTAG port. Takes one
// command (IR value + shift-register word) at a time and plays the virtual
// JTAG sequence update-IR, capture-DR, SR_WIDTH x shift-DR, update-DR on the
// vji_* pins. The TDO bits captured during shift-DR come back as the response.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   cmd_valid/ready/ir/data command channel (data shifted LSB first)
//   rsp_valid/ready/data    response channel (bit 0 = first bit shifted out)
//   vji_tck, vji_tdi        generated test clock and serial data to slave
//   vji_tdo                 serial data from slave
//   vji_ir_in               virtual IR value, held until the next update-IR
//   vji_uir/cdr/sdr/udr     virtual-state indicators
//   vji_rti                 run-test-idle indicator (high when not sequencing)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer keeps valid and its payload stable until that edge;
// ready never depends on valid in the same cycle.
// ---------------------------------------------------------------------------
module debug_slave_vjtag_host #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PERIOD = 2 * TCK_DIV;
    localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BIT_W  = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PERIOD - 1);
    // Last low-phase cycle of a period: TDO is sampled here, tck rises next.
    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH   = DIV_W'(TCK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SR_WIDTH-1:0] data_q, data_d;
    logic [SR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;

    logic cmd_ready_q, cmd_ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic tck_q, tck_d;
    logic tdi_q, tdi_d;
    logic uir_q, uir_d;
    logic cdr_q, cdr_d;
    logic sdr_q, sdr_d;
    logic udr_q, udr_d;
    logic rti_q, rti_d;

    logic period_end;
    logic busy_d;

    // State register: every output is a flop so the pins are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            ir_in_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            ir_in_q     <= ir_in_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
        end
    end

    // Next-state logic. div counts clk cycles within one tck period; a new
    // period (tck falling) begins whenever div returns to 0.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        ir_in_d    = ir_in_q;
        period_end = (div_q == DIV_LAST);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_UIR;
                    div_d   = '0;
                    bit_d   = '0;
                    data_d  = cmd_data;
                    ir_in_d = cmd_ir;
                end
            end
            ST_UIR: begin
                if (period_end) begin
                    state_d = ST_CDR;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_CDR: begin
                if (period_end) begin
                    state_d = ST_SDR;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SDR: begin
                if (div_q == DIV_SAMPLE) begin
                    rsp_data_d[bit_q] = vji_tdo;
                end
                if (period_end) begin
                    div_d  = '0;
                    // data_q[0] always holds the bit for the current period.
                    data_d = data_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_UDR: begin
                if (period_end) begin
                    state_d = ST_RSP;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Output logic, decoded from the next state so outputs change on the same
    // edge as the state (i.e. at period start / tck falling edge).
    always_comb begin
        busy_d      = (state_d == ST_UIR) || (state_d == ST_CDR) ||
                      (state_d == ST_SDR) || (state_d == ST_UDR);
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RSP);
        tck_d       = busy_d && (div_d >= DIV_HIGH);
        tdi_d       = (state_d == ST_SDR) && data_d[0];
        uir_d       = (state_d == ST_UIR);
        cdr_d       = (state_d == ST_CDR);
        sdr_d       = (state_d == ST_SDR);
        udr_d       = (state_d == ST_UDR);
        rti_d       = !busy_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;

endmodule

// File: tb/tb_debug_slave_vjtag_host.sv
// ---------------------------------------------------------------------------
// tb_debug_slave_vjtag_host
//
// Drives debug_slave_vjtag_host (TCK_DIV=2) and a second copy with TCK_DIV=1
// against loopback slave models: each slave captures a preload word on
// capture-DR and shifts TDI in at the MSB on every tck rise during shift-DR,
// so the response equals the preload and the slave ends holding cmd_data.
// ---------------------------------------------------------------------------
module tb_debug_slave_vjtag_host;

    localparam int SRW = 38;
    localparam int IRW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [SRW-1:0] exp_q[$];
    logic [SRW-1:0] exp1_q[$];

    // Main DUT (TCK_DIV=2)
    logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [IRW-1:0] cmd_ir, ir_in;
    logic [SRW-1:0] cmd_data, rsp_data;
    logic           tck, tdi, tdo, uir, cdr, sdr, udr, rti;

    debug_slave_vjtag_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
        .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti)
    );

    // Second DUT (TCK_DIV=1)
    logic           cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1;
    logic [IRW-1:0] cmd_ir_1, ir_in_1;
    logic [SRW-1:0] cmd_data_1, rsp_data_1;
    logic           tck_1, tdi_1, tdo_1, uir_1, cdr_1, sdr_1, udr_1, rti_1;

    debug_slave_vjtag_host #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1), .cmd_ir(cmd_ir_1), .cmd_data(cmd_data_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_data(rsp_data_1),
        .vji_tck(tck_1), .vji_tdi(tdi_1), .vji_tdo(tdo_1), .vji_ir_in(ir_in_1),
        .vji_uir(uir_1), .vji_cdr(cdr_1), .vji_sdr(sdr_1), .vji_udr(udr_1), .vji_rti(rti_1)
    );

    // Loopback slave models
    logic [SRW-1:0] slave_sr = '0;
    logic [SRW-1:0] slave_preload = '0;
    always @(posedge tck) begin
        if (cdr) slave_sr <= slave_preload;
        else if (sdr) slave_sr <= {tdi, slave_sr[SRW-1:1]};
    end
    assign tdo = slave_sr[0];

    logic [SRW-1:0] slave1_sr = '0;
    logic [SRW-1:0] slave1_preload = '0;
    always @(posedge tck_1) begin
        if (cdr_1) slave1_sr <= slave1_preload;
        else if (sdr_1) slave1_sr <= {tdi_1, slave1_sr[SRW-1:1]};
    end
    assign tdo_1 = slave1_sr[0];

    // Monitors: running totals, read as differences by the tests
    int sdr_rises = 0;
    always @(posedge tck) if (sdr) sdr_rises <= sdr_rises + 1;

    int uir_cyc = 0, cdr_cyc = 0, udr_cyc = 0, rti_busy_cyc = 0;
    always @(negedge clk) begin
        if (uir) uir_cyc <= uir_cyc + 1;
        if (cdr) cdr_cyc <= cdr_cyc + 1;
        if (udr) udr_cyc <= udr_cyc + 1;
        if ((uir || cdr || sdr || udr) && rti) rti_busy_cyc <= rti_busy_cyc + 1;
    end

    logic busy1_prev = 1'b0;
    logic tck1_prev = 1'b0;
    int   tck1_bad = 0;
    int   tck1_toggles = 0;
    always @(negedge clk) begin
        if ((uir_1 || cdr_1 || sdr_1 || udr_1) && busy1_prev) begin
            if (tck_1 === tck1_prev) tck1_bad <= tck1_bad + 1;
            else tck1_toggles <= tck1_toggles + 1;
        end
        busy1_prev <= uir_1 || cdr_1 || sdr_1 || udr_1;
        tck1_prev  <= tck_1;
    end

    // Driver tasks (entered and left on a negedge)
    task automatic issue(input logic [IRW-1:0] ir, input logic [SRW-1:0] data, output int acc);
        cmd_ir = ir;
        cmd_data = data;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (acc < 0) begin
            tests_failed++;
            $display("FAIL accept: cmd_ready never high (required 1 within 400 cycles)");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int acc, input int lat, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < lat + 50; i++) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s latency: rsp_valid never seen, required at accept+%0d", name, lat);
        end else if (cyc - acc != lat) begin
            tests_failed++;
            $display("FAIL %s latency: got accept+%0d, required accept+%0d", name, cyc - acc, lat);
        end
    endtask

    task automatic take_rsp(input string name);
        logic [SRW-1:0] exp;
        rsp_ready = 1'b1;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: response with empty expected queue", name);
        end else begin
            exp = exp_q.pop_front();
            if (rsp_data !== exp) begin
                tests_failed++;
                $display("FAIL %s rsp_data: got %h, required %h", name, rsp_data, exp);
            end
        end
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL %s release: {cmd_ready,rsp_valid}=%b, required 10", name, {cmd_ready, rsp_valid});
        end
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti} !== 9'b100000001) begin
            tests_failed++;
            $display("FAIL reset ctrl: got %b, required 100000001",
                     {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti});
        end
        tests_run++;
        if ({ir_in, rsp_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset data: ir_in=%b rsp_data=%h, required 0 and 0", ir_in, rsp_data);
        end
        tests_run++;
        if ({cmd_ready_1, rsp_valid_1, tck_1, rti_1} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL reset dut1: got %b, required 1001", {cmd_ready_1, rsp_valid_1, tck_1, rti_1});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_cmd();
        int acc;
        int seen;
        rsp_ready = 1'b1;
        slave_preload = {$urandom_range(63, 0), $urandom};
        issue(2'b11, {$urandom_range(63, 0), $urandom}, acc);
        while (cyc < acc + 60) @(negedge clk);
        tests_run++;
        if (sdr !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort pre: sdr=%b, required 1", sdr);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti} !== 9'b100000001) begin
            tests_failed++;
            $display("FAIL abort ctrl: got %b, required 100000001",
                     {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti});
        end
        tests_run++;
        if ({ir_in, rsp_data} !== '0) begin
            tests_failed++;
            $display("FAIL abort data: ir_in=%b rsp_data=%h, required 0 and 0", ir_in, rsp_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort ready: cmd_ready=%b, required 1", cmd_ready);
        end
        seen = 0;
        repeat (200) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort rsp: rsp_valid high for %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_single_and_edges();
        int acc;
        int r0, u0, c0, d0, b0;
        logic [SRW-1:0] data;
        data = 38'h2A_5A5A_5A5A;
        rsp_ready = 1'b0;
        r0 = sdr_rises; u0 = uir_cyc; c0 = cdr_cyc; d0 = udr_cyc; b0 = rti_busy_cyc;
        slave_preload = 38'h15_DEAD_BEEF;
        issue(2'b01, data, acc);
        exp_q.push_back(38'h15_DEAD_BEEF);
        tests_run++;
        if ({uir, ir_in} !== 3'b101) begin
            tests_failed++;
            $display("FAIL single uir: {uir,ir_in}=%b, required 101", {uir, ir_in});
        end
        wait_rsp(acc, 165, "single");
        tests_run++;
        if (slave_sr !== data) begin
            tests_failed++;
            $display("FAIL single slave: got %h, required %h", slave_sr, data);
        end
        take_rsp("single");
        tests_run++;
        if (sdr_rises - r0 != SRW) begin
            tests_failed++;
            $display("FAIL edges sdr_tck: got %0d, required %0d", sdr_rises - r0, SRW);
        end
        tests_run++;
        if ((uir_cyc - u0 != 4) || (cdr_cyc - c0 != 4) || (udr_cyc - d0 != 4)) begin
            tests_failed++;
            $display("FAIL edges widths: uir=%0d cdr=%0d udr=%0d, required 4 each",
                     uir_cyc - u0, cdr_cyc - c0, udr_cyc - d0);
        end
        tests_run++;
        if (rti_busy_cyc - b0 != 0) begin
            tests_failed++;
            $display("FAIL edges rti: high for %0d busy cycles, required 0", rti_busy_cyc - b0);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int bad_v, bad_d, bad_r, bad_u;
        rsp_ready = 1'b0;
        slave_preload = {$urandom_range(63, 0), $urandom};
        issue(2'b11, {$urandom_range(63, 0), $urandom}, acc);
        exp_q.push_back(slave_preload);
        wait_rsp(acc, 165, "bp");
        bad_v = 0; bad_d = 0; bad_r = 0; bad_u = 0;
        cmd_valid = 1'b1;
        cmd_ir = 2'b00;
        cmd_data = {$urandom_range(63, 0), $urandom};
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1) bad_v++;
            if (rsp_data !== exp_q[0]) bad_d++;
            if (cmd_ready !== 1'b0) bad_r++;
            if ({uir, ir_in} !== 3'b011) bad_u++;
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (bad_v != 0) begin
            tests_failed++;
            $display("FAIL bp rsp_valid: dropped in %0d cycles, required 0", bad_v);
        end
        tests_run++;
        if (bad_d != 0) begin
            tests_failed++;
            $display("FAIL bp rsp_data: changed in %0d cycles, required 0", bad_d);
        end
        tests_run++;
        if ((bad_r != 0) || (bad_u != 0)) begin
            tests_failed++;
            $display("FAIL bp busy cmd: ready %0d / uir-ir %0d cycles wrong, required 0", bad_r, bad_u);
        end
        take_rsp("bp");
    endtask

    task automatic test_back_to_back();
        int acc, acc2, r;
        logic [SRW-1:0] exp;
        rsp_ready = 1'b1;
        slave_preload = {$urandom_range(63, 0), $urandom};
        issue(2'b00, {$urandom_range(63, 0), $urandom}, acc);
        exp_q.push_back(slave_preload);
        wait_rsp(acc, 165, "b2b first");
        r = cyc;
        exp = exp_q.pop_front();
        tests_run++;
        if (rsp_data !== exp) begin
            tests_failed++;
            $display("FAIL b2b first rsp_data: got %h, required %h", rsp_data, exp);
        end
        slave_preload = {$urandom_range(63, 0), $urandom};
        cmd_valid = 1'b1;
        cmd_ir = 2'b10;
        cmd_data = {$urandom_range(63, 0), $urandom};
        @(negedge clk);
        acc2 = cyc;
        tests_run++;
        if ({cmd_ready, rsp_valid} !== 2'b10 || acc2 != r + 1) begin
            tests_failed++;
            $display("FAIL b2b accept: {cmd_ready,rsp_valid}=%b at R+%0d, required 10 at R+1",
                     {cmd_ready, rsp_valid}, acc2 - r);
        end
        exp_q.push_back(slave_preload);
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if ({uir, ir_in} !== 3'b110) begin
            tests_failed++;
            $display("FAIL b2b uir: {uir,ir_in}=%b, required 110", {uir, ir_in});
        end
        wait_rsp(acc2, 165, "b2b second");
        take_rsp("b2b second");
    endtask

    task automatic test_min_divider();
        int acc;
        int bad0, tog0;
        logic got;
        logic [SRW-1:0] exp;
        rsp_ready_1 = 1'b1;
        bad0 = tck1_bad;
        tog0 = tck1_toggles;
        slave1_preload = {$urandom_range(63, 0), $urandom};
        cmd_ir_1 = 2'b01;
        cmd_data_1 = {$urandom_range(63, 0), $urandom};
        cmd_valid_1 = 1'b1;
        acc = cyc;
        exp1_q.push_back(slave1_preload);
        @(negedge clk);
        cmd_valid_1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (rsp_valid_1 === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!got || (cyc - acc != 83)) begin
            tests_failed++;
            $display("FAIL div1 latency: seen=%b at accept+%0d, required accept+83", got, cyc - acc);
        end
        exp = exp1_q.pop_front();
        tests_run++;
        if (rsp_data_1 !== exp) begin
            tests_failed++;
            $display("FAIL div1 rsp_data: got %h, required %h", rsp_data_1, exp);
        end
        tests_run++;
        if ((tck1_bad - bad0 != 0) || (tck1_toggles - tog0 != 81)) begin
            tests_failed++;
            $display("FAIL div1 tck: %0d held / %0d toggles, required 0 / 81",
                     tck1_bad - bad0, tck1_toggles - tog0);
        end
        @(negedge clk);
        tests_run++;
        if ({cmd_ready_1, rsp_valid_1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL div1 release: {cmd_ready,rsp_valid}=%b, required 10", {cmd_ready_1, rsp_valid_1});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        cmd_valid_1 = 1'b0; cmd_ir_1 = '0; cmd_data_1 = '0; rsp_ready_1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_and_edges();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_cmd();
        test_min_divider();
        tests_run++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard drain: %0d/%0d left, required 0/0", exp_q.size(), exp1_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debug_slave_vjtag_host.md
# debug_slave_vjtag_host

Clocked host-side driver for the Nios II debug-slave virtual-JTAG port. It accepts one command at a time, each made of an IR value and a shift-register data word. For each command it generates the virtual JTAG sequence on the vji_* signals: update-IR, capture-DR, SR_WIDTH shift-DR bits, then update-DR. It returns the captured TDO word as the response. It replaces the tied-off vji_* simulation stubs so that benches and on-chip test logic can exercise the take_action decode path without a physical JTAG hub.

## Interface
Parameters:
- SR_WIDTH, 38, debug shift-register length in bits.
- IR_WIDTH, 2, virtual IR width in bits.
- TCK_DIV, 2, clk cycles per tck half-period; must be ≥1.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command (IDLE state).
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_data  in  SR_WIDTH  word to shift in, LSB first.
- rsp_valid  out  1  captured word is available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  SR_WIDTH  captured TDO word; bit 0 is the first bit shifted out.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  virtual IR value.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual-state indicators.
- vji_rti  out  1  run-test-idle indicator.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RSP. All outputs are registered.
- Reset values:
  - Control and vji outputs: cmd_ready=1, rsp_valid=0, vji_tck=0, vji_tdi=0, vji_uir/cdr/sdr/udr=0, vji_rti=1.
  - Data outputs: vji_ir_in=0, rsp_data=0.
  - Internal: divider counter=0, bit counter=0.
- IDLE:
  - tck is held at 0, rti=1, cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_ir and cmd_data, drop cmd_ready, go to UIR.
- tck generation (all states except IDLE and RSP):
  - tck is low for TCK_DIV cycles, then high for TCK_DIV cycles.
  - A "period" starts at the cycle tck is driven low.
  - State, tdi and indicator changes occur only at period start, i.e. the falling edge.
- UIR (1 period): uir=1, vji_ir_in = latched IR, rti=0.
- CDR (1 period): cdr=1.
- SDR (SR_WIDTH periods):
  - sdr=1. In period k (0..SR_WIDTH-1), tdi = data[k].
  - vji_tdo is sampled in the last low-phase cycle of period k, just before tck rises, into rsp_data[k].
- UDR (1 period): udr=1. After it, tck is held at 0 and the state goes to RSP.
- RSP:
  - rsp_valid=1, rsp_data is stable, rti=1.
  - On rsp_ready, the next cycle has rsp_valid=0, cmd_ready=1 and state IDLE.
- vji_ir_in holds the last loaded IR until the next UIR.
- Commands offered while busy are not accepted; cmd_ready=0 from the cycle after acceptance until the return to IDLE.
- Reset mid-command: all outputs return to their reset values immediately. No response is produced and the partially shifted data is discarded.
- The bit counter is sized ceil(log2(SR_WIDTH)). It does not wrap; the SDR→UDR transition happens at count SR_WIDTH-1 at period end.

## Timing
- Period P = 2*TCK_DIV clk cycles.
- Accept at cycle T:
  - UIR starts at T+1.
  - CDR starts at T+1+P.
  - SDR starts at T+1+2P.
  - UDR starts at T+1+(2+SR_WIDTH)P.
  - rsp_valid rises at T+1+(3+SR_WIDTH)P.
- Defaults (TCK_DIV=2, SR_WIDTH=38, P=4): rsp_valid at T+165.
- rsp_valid&&rsp_ready at cycle R gives cmd_ready=1 at R+1. The earliest next accept is R+1.
- Throughput: one command per (3+SR_WIDTH)P+2 cycles when the response is accepted immediately.
- Exactly one uir, one cdr and one udr period per command, and exactly SR_WIDTH rising tck edges during sdr.

## Test plan
- Reset behaviour: assert reset mid-SDR of a command → same cycle all outputs return to reset values. After release cmd_ready=1, and no rsp_valid appears for the aborted command.
- Single command: cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A, TCK_DIV=2, loopback slave model (38-bit shift reg preloaded 38'h15_DEAD_BEEF in CDR) → rsp_valid at accept+165 and rsp_data=38'h15_DEAD_BEEF. The slave register holds 38'h2A_5A5A_5A5A at udr.
- Edge counting: count vji_tck rising edges while sdr=1 → exactly 38. uir, cdr and udr are each high for exactly 4 cycles, and rti=0 throughout.
- Backpressure: hold rsp_ready=0 for 50 cycles after rsp_valid → rsp_valid and rsp_data stay stable and cmd_valid is ignored. Release → cmd_ready=1 on the next cycle.
- Back-to-back commands: ir=2'b00 then ir=2'b10 with rsp_ready tied 1 → second uir period shows vji_ir_in=2'b10. Second accept occurs at cycle R+1.
- Minimum divider: TCK_DIV=1 → tck toggles every clk cycle and rsp_valid appears at accept+1+41*2=accept+83.
